// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong game types, widths and default constants
//
// Contents:
//   game_state_t        game flow states: IDLE, SERVE, PLAY, OVER
//   SCORE_W / SPEED_W   score and speed bus widths
//   TIMER_W             width of the shared serve/speed-step timer
//   DEFAULT_WIN_SCORE   default points to win, also used by the scoreboard stage
//   DEFAULT_SPEED_INIT  default serve speed, also used by the scoreboard stage
//   speed_step()        saturating +1 on the ball speed

package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int SCORE_W = 4;
  localparam int SPEED_W = 5;
  localparam int TIMER_W = 16;

  localparam int DEFAULT_WIN_SCORE  = 9;
  localparam int DEFAULT_SPEED_INIT = 4;

  // Increment speed by one without ever passing the ceiling or wrapping.
  function automatic logic [SPEED_W-1:0] speed_step(
    input logic [SPEED_W-1:0] cur,
    input logic [SPEED_W-1:0] ceiling
  );
    if (cur >= ceiling) begin
      return ceiling;
    end
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong game-flow controller: scores, serve/play/over sequencing, speed ramp
//
// Ports:
//   clk         in   game clock, shared with the ball stage
//   reset       in   asynchronous active-low reset
//   start       in   synchronised start button level, acted on at its rising edge
//   out_left    in   ball hit the far-left edge (right player scores)
//   out_right   in   ball hit the far-right edge (left player scores)
//   ball_reset  out  holds the ball stage at centre while high
//   speed       out  ball speed, 1..15
//   lscore      out  left player score
//   rscore      out  right player score
//   serving     out  high during the serve hold
//   game_over   out  high once a player has reached WIN_SCORE
//   winner      out  0 = left won, 1 = right won; meaningful with game_over

module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE         = DEFAULT_WIN_SCORE,
  parameter int SERVE_CYCLES      = 2000,
  parameter int SPEED_INIT        = DEFAULT_SPEED_INIT,
  parameter int SPEED_MAX         = 15,
  parameter int SPEED_STEP_CYCLES = 4000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               out_left,
  input  logic               out_right,
  output logic               ball_reset,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] lscore,
  output logic [SCORE_W-1:0] rscore,
  output logic               serving,
  output logic               game_over,
  output logic               winner
);

  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STEP_LAST  = TIMER_W'(SPEED_STEP_CYCLES - 1);
  localparam logic [SPEED_W-1:0] SPD_INIT   = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] WIN_PTS    = SCORE_W'(WIN_SCORE);

  game_state_t        state;
  logic [TIMER_W-1:0] timer;
  logic               start_q;

  logic               start_rise;
  logic [SCORE_W-1:0] lscore_inc;
  logic [SCORE_W-1:0] rscore_inc;

  assign start_rise = start & ~start_q;
  assign lscore_inc = lscore + 1'b1;
  assign rscore_inc = rscore + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      start_q    <= 1'b0;
      ball_reset <= 1'b1;
      speed      <= SPD_INIT;
      lscore     <= '0;
      rscore     <= '0;
      serving    <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      start_q <= start;

      case (state)
        // IDLE and OVER both start a fresh game on the button edge; in OVER
        // the scores and winner stay frozen until then.
        IDLE, OVER: begin
          ball_reset <= 1'b1;
          if (start_rise) begin
            state     <= SERVE;
            lscore    <= '0;
            rscore    <= '0;
            speed     <= SPD_INIT;
            timer     <= '0;
            serving   <= 1'b1;
            game_over <= 1'b0;
            winner    <= 1'b0;
          end
        end

        SERVE: begin
          if (timer == SERVE_LAST) begin
            state      <= PLAY;
            timer      <= '0;
            serving    <= 1'b0;
            ball_reset <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PLAY: begin
          // Any edge event outranks a coinciding speed step. Once we leave
          // PLAY the ball stage's still-high event is ignored, so a pulse
          // that lasts several cycles scores exactly once.
          if (out_left || out_right) begin
            ball_reset <= 1'b1;
            speed      <= SPD_INIT;
            timer      <= '0;
            if (out_left && out_right) begin
              state   <= SERVE;
              serving <= 1'b1;
            end else if (out_right) begin
              lscore <= lscore_inc;
              if (lscore_inc == WIN_PTS) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b0;
              end else begin
                state   <= SERVE;
                serving <= 1'b1;
              end
            end else begin
              rscore <= rscore_inc;
              if (rscore_inc == WIN_PTS) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b1;
              end else begin
                state   <= SERVE;
                serving <= 1'b1;
              end
            end
          end else if (timer == STEP_LAST) begin
            timer <= '0;
            speed <= speed_step(speed, SPD_MAX);
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
